// File: rtl/tile_color_pkg.sv
// Shared types and constants for the tile/palette colour mapper:
// pixel colour struct, boot-time palette, world width helper and FSM states.
package tile_color_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam int DEF_PAL_N = 4;

    localparam logic [23:0] DEF_PAL [DEF_PAL_N] = '{
        24'h00_00_7F,
        24'h8D_FC_C7,
        24'h11_5C_C7,
        24'h22_FC_AA
    };

    // Entries beyond the boot table come up black.
    function automatic rgb_t default_pal(input int idx);
        logic [1:0] sel;
        sel = 2'(idx);
        if (idx < DEF_PAL_N) begin
            return rgb_t'(DEF_PAL[sel]);
        end
        return '0;
    endfunction

    function automatic int WORLD_W(input int map_w, input int tile_shift);
        return map_w << tile_shift;
    endfunction

endpackage

// File: rtl/tile_map_ram.sv
// Tile index store: one write port, one registered read port.
// A read of the cell being written in the same cycle returns the previous contents.
module tile_map_ram #(
    parameter int DEPTH  = 300,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tile_color_mapper.sv
// Two-stage pixel colour pipeline: scrolled tile map through a writable palette,
// with solid sprite boxes on top. An init FSM reloads map and palette after reset.
module tile_color_mapper
    import tile_color_pkg::*;
#(
    parameter int TILE_SHIFT  = 5,
    parameter int MAP_W       = 20,
    parameter int MAP_H       = 15,
    parameter int IDX_W       = 2,
    parameter int NUM_SPRITES = 2
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      blank,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic [10:0]               scroll_x,
    input  logic                      map_we,
    input  logic [4:0]                map_col,
    input  logic [3:0]                map_row,
    input  logic [IDX_W-1:0]          map_wdata,
    input  logic                      pal_we,
    input  logic [IDX_W-1:0]          pal_idx,
    input  logic [23:0]               pal_rgb,
    input  logic [NUM_SPRITES-1:0]    spr_en,
    input  logic [NUM_SPRITES*10-1:0] spr_x,
    input  logic [NUM_SPRITES*10-1:0] spr_y,
    input  logic [NUM_SPRITES*10-1:0] spr_hw,
    input  logic [NUM_SPRITES*10-1:0] spr_hh,
    input  logic [NUM_SPRITES*24-1:0] spr_rgb,
    output logic                      init_done,
    output logic [7:0]                Red,
    output logic [7:0]                Green,
    output logic [7:0]                Blue
);

    localparam int          CELLS     = MAP_W * MAP_H;
    localparam int          ADDR_W    = $clog2(CELLS);
    localparam int          COL_W     = $clog2(MAP_W);
    localparam int          ROW_W     = $clog2(MAP_H);
    localparam int          PAL_DEPTH = 2 ** IDX_W;
    localparam logic [10:0] WORLD_PIX = 11'(WORLD_W(MAP_W, TILE_SHIFT));

    // ---------------- init FSM ----------------
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cell_q, cell_d;
    logic [COL_W-1:0]  icol_q, icol_d;
    logic [ROW_W-1:0]  irow_q, irow_d;
    logic              init_done_q, init_done_d;

    always_comb begin
        state_d     = state_q;
        cell_d      = cell_q;
        icol_d      = icol_q;
        irow_d      = irow_q;
        init_done_d = init_done_q;
        if (state_q == INIT) begin
            if (cell_q == ADDR_W'(CELLS - 1)) begin
                state_d     = RUN;
                init_done_d = 1'b1;
                cell_d      = '0;
                icol_d      = '0;
                irow_d      = '0;
            end else begin
                cell_d = cell_q + 1'b1;
                if (icol_q == COL_W'(MAP_W - 1)) begin
                    icol_d = '0;
                    irow_d = irow_q + 1'b1;
                end else begin
                    icol_d = icol_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= INIT;
            cell_q      <= '0;
            icol_q      <= '0;
            irow_q      <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cell_q      <= cell_d;
            icol_q      <= icol_d;
            irow_q      <= irow_d;
            init_done_q <= init_done_d;
        end
    end

    assign init_done = init_done_q;

    // ---------------- map write port: init sweep or game logic ----------------
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [IDX_W-1:0]  ram_wdata;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        if (state_q == INIT) begin
            ram_we    = 1'b1;
            ram_waddr = cell_q;
            ram_wdata = IDX_W'(irow_q + icol_q);
        end else begin
            ram_we    = map_we && (map_col < 5'(MAP_W)) && (map_row < 4'(MAP_H));
            ram_waddr = ADDR_W'(int'(map_row) * MAP_W + int'(map_col));
            ram_wdata = map_wdata;
        end
    end

    // ---------------- palette ----------------
    rgb_t pal_q [PAL_DEPTH];
    rgb_t pal_d [PAL_DEPTH];

    always_comb begin
        pal_d = pal_q;
        if (state_q == INIT && cell_q == '0) begin
            for (int i = 0; i < PAL_DEPTH; i++) begin
                pal_d[i] = default_pal(i);
            end
        end else if (state_q == RUN && pal_we) begin
            pal_d[pal_idx] = rgb_t'(pal_rgb);
        end
    end

    always_ff @(posedge Clk) begin
        pal_q <= pal_d;
    end

    // ---------------- S1: scroll, map address, sprite hits ----------------
    logic [10:0]       wx_sum, wx, col_c;
    logic [9:0]        row_c;
    logic              map_oob;
    logic [ADDR_W-1:0] rd_addr;
    logic [10:0]       px, py;

    // One conditional subtract suffices while scroll_x stays within the world width.
    always_comb begin
        wx_sum  = {1'b0, DrawX} + scroll_x;
        wx      = (wx_sum >= WORLD_PIX) ? (wx_sum - WORLD_PIX) : wx_sum;
        col_c   = wx >> TILE_SHIFT;
        row_c   = DrawY >> TILE_SHIFT;
        // Off-map columns (only reachable with DrawX beyond the world) share the row-overflow handling.
        map_oob = (row_c >= 10'(MAP_H)) || (col_c >= 11'(MAP_W));
        rd_addr = map_oob ? '0 : ADDR_W'(int'(row_c) * MAP_W + int'(col_c));
        px      = {1'b0, DrawX};
        py      = {1'b0, DrawY};
    end

    logic [IDX_W-1:0] tile_idx;

    tile_map_ram #(
        .DEPTH  (CELLS),
        .ADDR_W (ADDR_W),
        .DATA_W (IDX_W)
    ) u_map (
        .clk   (Clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (tile_idx)
    );

    logic [NUM_SPRITES-1:0] hit_c;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_spr
            logic [10:0] sx, sy, shw, shh;
            assign sx  = {1'b0, spr_x[gi*10 +: 10]};
            assign sy  = {1'b0, spr_y[gi*10 +: 10]};
            assign shw = {1'b0, spr_hw[gi*10 +: 10]};
            assign shh = {1'b0, spr_hh[gi*10 +: 10]};
            assign hit_c[gi] = spr_en[gi]
                             && (px + shw >= sx) && (px <= sx + shw)
                             && (py + shh >= sy) && (py <= sy + shh);
        end
    endgenerate

    logic                      s1_blank_q, s1_blank_d;
    logic                      s1_oob_q, s1_oob_d;
    logic [NUM_SPRITES-1:0]    s1_hit_q, s1_hit_d;
    logic [NUM_SPRITES*24-1:0] s1_spr_rgb_q, s1_spr_rgb_d;

    always_comb begin
        s1_blank_d   = blank;
        s1_oob_d     = map_oob;
        s1_hit_d     = hit_c;
        s1_spr_rgb_d = spr_rgb;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_blank_q   <= 1'b0;
            s1_oob_q     <= 1'b0;
            s1_hit_q     <= '0;
            s1_spr_rgb_q <= '0;
        end else begin
            s1_blank_q   <= s1_blank_d;
            s1_oob_q     <= s1_oob_d;
            s1_hit_q     <= s1_hit_d;
            s1_spr_rgb_q <= s1_spr_rgb_d;
        end
    end

    // ---------------- S2: palette lookup and sprite priority ----------------
    rgb_t rgb_q, rgb_d;

    always_comb begin
        rgb_d = '0;
        if (state_q == RUN && s1_blank_q) begin
            rgb_d = s1_oob_q ? pal_q[0] : pal_q[tile_idx];
            // Walk from the highest index down so sprite 0 ends up on top.
            for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
                if (s1_hit_q[i]) begin
                    rgb_d = rgb_t'(s1_spr_rgb_q[i*24 +: 24]);
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign Red   = rgb_q.r;
    assign Green = rgb_q.g;
    assign Blue  = rgb_q.b;

endmodule

// File: tb/tb_tile_color_mapper.sv
// Self-checking bench for tile_color_mapper: directed scenarios plus randomized
// pixels compared against a world-coordinate model of map, palette and sprites.
module tb_tile_color_mapper;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        blank = 1'b0;
    logic [9:0]  draw_x = '0;
    logic [9:0]  draw_y = '0;
    logic [10:0] scroll_x = '0;
    logic        map_we = 1'b0;
    logic [4:0]  map_col = '0;
    logic [3:0]  map_row = '0;
    logic [1:0]  map_wdata = '0;
    logic        pal_we = 1'b0;
    logic [1:0]  pal_idx = '0;
    logic [23:0] pal_rgb = '0;
    logic [1:0]  spr_en = '0;
    logic [19:0] spr_x = '0;
    logic [19:0] spr_y = '0;
    logic [19:0] spr_hw = '0;
    logic [19:0] spr_hh = '0;
    logic [47:0] spr_rgb = '0;
    logic        init_done;
    logic [7:0]  red, green, blue;

    int checks = 0;
    int failures = 0;

    int          map_m [15][20];
    logic [23:0] pal_m [4];

    tile_color_mapper dut (
        .Clk       (clk),
        .Reset     (reset),
        .blank     (blank),
        .DrawX     (draw_x),
        .DrawY     (draw_y),
        .scroll_x  (scroll_x),
        .map_we    (map_we),
        .map_col   (map_col),
        .map_row   (map_row),
        .map_wdata (map_wdata),
        .pal_we    (pal_we),
        .pal_idx   (pal_idx),
        .pal_rgb   (pal_rgb),
        .spr_en    (spr_en),
        .spr_x     (spr_x),
        .spr_y     (spr_y),
        .spr_hw    (spr_hw),
        .spr_hh    (spr_hh),
        .spr_rgb   (spr_rgb),
        .init_done (init_done),
        .Red       (red),
        .Green     (green),
        .Blue      (blue)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic reset_model();
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 20; c++)
                map_m[r][c] = (r + c) % 4;
        pal_m[0] = 24'h00007F;
        pal_m[1] = 24'h8DFCC7;
        pal_m[2] = 24'h115CC7;
        pal_m[3] = 24'h22FCAA;
    endtask

    function automatic logic [23:0] ref_pixel(input logic bl, input int dx, input int dy, input int sc);
        int sx, sy, hw, hh, wx, col, row;
        if (bl !== 1'b1) return 24'h0;
        for (int k = 0; k < 2; k++) begin
            sx = int'(spr_x[k*10 +: 10]);
            sy = int'(spr_y[k*10 +: 10]);
            hw = int'(spr_hw[k*10 +: 10]);
            hh = int'(spr_hh[k*10 +: 10]);
            if (spr_en[k] && dx + hw >= sx && dx <= sx + hw && dy + hh >= sy && dy <= sy + hh)
                return spr_rgb[k*24 +: 24];
        end
        wx  = (dx + sc) % 640;
        col = wx / 32;
        row = dy / 32;
        if (row >= 15) return pal_m[0];
        return pal_m[map_m[row][col]];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_spr(input int k, input int x, input int y, input int hw, input int hh,
                           input logic [23:0] c, input logic en);
        spr_x[k*10 +: 10]   = 10'(x);
        spr_y[k*10 +: 10]   = 10'(y);
        spr_hw[k*10 +: 10]  = 10'(hw);
        spr_hh[k*10 +: 10]  = 10'(hh);
        spr_rgb[k*24 +: 24] = c;
        spr_en[k]           = en;
    endtask

    task automatic rand_sprites();
        for (int k = 0; k < 2; k++)
            set_spr(k, int'($urandom_range(639)), int'($urandom_range(479)),
                    int'($urandom_range(120)), int'($urandom_range(120)),
                    24'($urandom), 1'($urandom_range(1)));
    endtask

    // Present a pixel and wait out the two-cycle latency; called at posedge+1.
    task automatic pixel(input logic bl, input int x, input int y, input int sc);
        blank    = bl;
        draw_x   = 10'(x);
        draw_y   = 10'(y);
        scroll_x = 11'(sc);
        @(posedge clk); @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int lat;
        reset = 1'b1; blank = 1'b1; draw_x = 10'd33; draw_y = '0; scroll_x = '0;
        @(posedge clk); #1;
        checks++;
        if ({red, green, blue} !== 24'h0)
            $display("FAIL reset_rgb got=%06h exp=000000", {red, green, blue});
        checks++;
        if (init_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_init_done got=%b exp=0", init_done);
        end
        if ({red, green, blue} !== 24'h0) failures++;
        reset = 1'b0;
        lat = -1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            if (n == 150) begin
                checks++;
                if ({red, green, blue} !== 24'h0) begin
                    failures++;
                    $display("FAIL init_rgb_zero got=%06h exp=000000", {red, green, blue});
                end
            end
            if (init_done === 1'b1) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat != 300) begin
            failures++;
            $display("FAIL init_latency got=%0d exp=300", lat);
        end
        $display("test_reset: init_done after %0d cycles", lat);
    endtask

    task automatic test_init_readback();
        pixel(1'b1, 33, 0, 0);
        checks++;
        if ({red, green, blue} !== 24'h8DFCC7) begin
            failures++;
            $display("FAIL init_readback got=%06h exp=8dfcc7", {red, green, blue});
        end
        $display("test_init_readback: (33,0) -> %06h", {red, green, blue});
    endtask

    task automatic test_blank();
        set_spr(0, 100, 100, 8, 16, 24'hAABBCC, 1'b1);
        pixel(1'b0, 100, 100, 0);
        checks++;
        if ({red, green, blue} !== 24'h000000) begin
            failures++;
            $display("FAIL blank_black got=%06h exp=000000", {red, green, blue});
        end
        spr_en = '0;
        pixel(1'b1, 0, 0, 0);
        checks++;
        if ({red, green, blue} !== 24'h00007F) begin
            failures++;
            $display("FAIL blank_idx0 got=%06h exp=00007f", {red, green, blue});
        end
        $display("test_blank: done");
    endtask

    task automatic test_sprite_bounds();
        int          px [8] = '{92, 108, 100, 100, 91, 109, 100, 100};
        int          py [8] = '{100, 100, 84, 116, 100, 100, 83, 117};
        logic        hit [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [23:0] exp;
        set_spr(0, 100, 100, 8, 16, 24'hAABBCC, 1'b1);
        spr_en[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = hit[i] ? 24'hAABBCC : ref_pixel(1'b1, px[i], py[i], 0);
            pixel(1'b1, px[i], py[i], 0);
            checks++;
            if ({red, green, blue} !== exp) begin
                failures++;
                $display("FAIL sprite_edge(%0d,%0d) got=%06h exp=%06h", px[i], py[i], {red, green, blue}, exp);
            end
            $display("sprite_edge (%0d,%0d) -> %06h", px[i], py[i], {red, green, blue});
        end
        set_spr(1, 102, 100, 8, 8, 24'h112233, 1'b1);
        pixel(1'b1, 100, 100, 0);
        checks++;
        if ({red, green, blue} !== 24'hAABBCC) begin
            failures++;
            $display("FAIL sprite_priority got=%06h exp=aabbcc", {red, green, blue});
        end
        pixel(1'b1, 110, 100, 0);
        checks++;
        if ({red, green, blue} !== 24'h112233) begin
            failures++;
            $display("FAIL sprite1_only got=%06h exp=112233", {red, green, blue});
        end
        spr_en = '0;
        set_spr(0, 4, 100, 8, 4, 24'h5A5A5A, 1'b1);
        pixel(1'b1, 0, 100, 0);
        checks++;
        if ({red, green, blue} !== 24'h5A5A5A) begin
            failures++;
            $display("FAIL sprite_no_underflow got=%06h exp=5a5a5a", {red, green, blue});
        end
        spr_en = '0;
        $display("test_sprite_bounds: done");
    endtask

    task automatic test_scroll_wrap();
        pixel(1'b1, 20, 0, 630);
        checks++;
        if ({red, green, blue} !== 24'h00007F) begin
            failures++;
            $display("FAIL scroll_wrap_r0 got=%06h exp=00007f", {red, green, blue});
        end
        pixel(1'b1, 20, 40, 630);
        checks++;
        if ({red, green, blue} !== 24'h8DFCC7) begin
            failures++;
            $display("FAIL scroll_wrap_r1 got=%06h exp=8dfcc7", {red, green, blue});
        end
        pixel(1'b1, 33, 480, 0);
        checks++;
        if ({red, green, blue} !== 24'h00007F) begin
            failures++;
            $display("FAIL row_overflow got=%06h exp=00007f", {red, green, blue});
        end
        $display("test_scroll_wrap: done");
    endtask

    task automatic test_map_write();
        blank = 1'b1; draw_x = 10'd96; draw_y = 10'd64; scroll_x = '0;
        map_we = 1'b1; map_col = 5'd3; map_row = 4'd2; map_wdata = 2'd3;
        @(posedge clk); #1;
        map_we = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({red, green, blue} !== 24'h8DFCC7) begin
            failures++;
            $display("FAIL map_collision_old got=%06h exp=8dfcc7", {red, green, blue});
        end
        map_m[2][3] = 3;
        pixel(1'b1, 96, 64, 0);
        checks++;
        if ({red, green, blue} !== 24'h22FCAA) begin
            failures++;
            $display("FAIL map_write_new got=%06h exp=22fcaa", {red, green, blue});
        end
        map_we = 1'b1; map_col = 5'd20; map_row = 4'd2; map_wdata = 2'd0;
        @(posedge clk); #1;
        map_we = 1'b0;
        pixel(1'b1, 0, 96, 0);
        checks++;
        if ({red, green, blue} !== 24'h22FCAA) begin
            failures++;
            $display("FAIL map_col_oob_ignored got=%06h exp=22fcaa", {red, green, blue});
        end
        $display("test_map_write: done");
    endtask

    task automatic test_palette_write();
        blank = 1'b1; draw_x = 10'd64; draw_y = '0; scroll_x = '0;
        pal_we = 1'b1; pal_idx = 2'd2; pal_rgb = 24'h123456;
        @(posedge clk); #1;
        pal_we = 1'b0;
        @(posedge clk); #1;
        pal_m[2] = 24'h123456;
        checks++;
        if ({red, green, blue} !== 24'h123456) begin
            failures++;
            $display("FAIL palette_write got=%06h exp=123456", {red, green, blue});
        end
        $display("test_palette_write: idx2 -> %06h", {red, green, blue});
    endtask

    task automatic test_random();
        int          x, y, sc;
        logic        bl;
        logic [23:0] exp;
        for (int i = 0; i < 40; i++) begin
            rand_sprites();
            x  = int'($urandom_range(639));
            y  = int'($urandom_range(511));
            sc = int'($urandom_range(639));
            bl = ($urandom_range(7) != 0);
            exp = ref_pixel(bl, x, y, sc);
            pixel(bl, x, y, sc);
            checks++;
            if ({red, green, blue} !== exp) begin
                failures++;
                $display("FAIL random[%0d] (%0d,%0d,s%0d) got=%06h exp=%06h", i, x, y, sc, {red, green, blue}, exp);
            end
            $display("random[%0d] (%0d,%0d,s%0d,b%0d) -> %06h", i, x, y, sc, bl, {red, green, blue});
        end
        spr_en = '0;
    endtask

    task automatic test_back_to_back();
        logic [23:0] q [$];
        logic [23:0] exp;
        int          x, y, sc;
        logic        bl;
        for (int i = 0; i <= 60; i++) begin
            if (i < 60) begin
                rand_sprites();
                x  = int'($urandom_range(639));
                y  = int'($urandom_range(511));
                sc = int'($urandom_range(639));
                bl = ($urandom_range(7) != 0);
                blank = bl; draw_x = 10'(x); draw_y = 10'(y); scroll_x = 11'(sc);
                q.push_back(ref_pixel(bl, x, y, sc));
            end
            @(posedge clk); #1;
            if (i >= 1) begin
                exp = q.pop_front();
                checks++;
                if ({red, green, blue} !== exp) begin
                    failures++;
                    $display("FAIL b2b[%0d] got=%06h exp=%06h", i - 1, {red, green, blue}, exp);
                end
                $display("b2b[%0d] -> %06h", i - 1, {red, green, blue});
            end
        end
        spr_en = '0;
    endtask

    task automatic test_reset_mid_init();
        int lat;
        blank = 1'b1; draw_x = 10'd33; draw_y = '0; scroll_x = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({red, green, blue} !== 24'h0 || init_done !== 1'b0) begin
            failures++;
            $display("FAIL run_reset got=%06h/%b exp=000000/0", {red, green, blue}, init_done);
        end
        reset = 1'b0;
        for (int n = 1; n <= 150; n++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (init_done !== 1'b0) begin
            failures++;
            $display("FAIL mid_init_done got=%b exp=0", init_done);
        end
        pal_we = 1'b1; pal_idx = 2'd1; pal_rgb = 24'hFFFFFF;
        map_we = 1'b1; map_col = 5'd0; map_row = 4'd0; map_wdata = 2'd3;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({red, green, blue} !== 24'h0 || init_done !== 1'b0) begin
            failures++;
            $display("FAIL mid_init_reset got=%06h/%b exp=000000/0", {red, green, blue}, init_done);
        end
        reset = 1'b0;
        lat = -1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            if (n == 200) begin
                pal_we = 1'b0;
                map_we = 1'b0;
            end
            if (init_done === 1'b1) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat != 300) begin
            failures++;
            $display("FAIL reinit_latency got=%0d exp=300", lat);
        end
        reset_model();
        pixel(1'b1, 33, 0, 0);
        checks++;
        if ({red, green, blue} !== 24'h8DFCC7) begin
            failures++;
            $display("FAIL reinit_pal1 got=%06h exp=8dfcc7", {red, green, blue});
        end
        pixel(1'b1, 0, 0, 0);
        checks++;
        if ({red, green, blue} !== 24'h00007F) begin
            failures++;
            $display("FAIL reinit_cell00 got=%06h exp=00007f", {red, green, blue});
        end
        pixel(1'b1, 64, 0, 0);
        checks++;
        if ({red, green, blue} !== 24'h115CC7) begin
            failures++;
            $display("FAIL reinit_pal2 got=%06h exp=115cc7", {red, green, blue});
        end
        pixel(1'b1, 96, 64, 0);
        checks++;
        if ({red, green, blue} !== 24'h8DFCC7) begin
            failures++;
            $display("FAIL reinit_cell32 got=%06h exp=8dfcc7", {red, green, blue});
        end
        $display("test_reset_mid_init: init_done after %0d cycles", lat);
    endtask

    initial begin
        reset_model();
        @(posedge clk); #1;
        test_reset();
        test_init_readback();
        test_blank();
        test_sprite_bounds();
        test_scroll_wrap();
        test_map_write();
        test_palette_write();
        test_random();
        test_back_to_back();
        test_reset_mid_init();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tile_color_mapper.md
Name: tile_color_mapper

Overview:
- Pipelined pixel colour generator between the VGA timing controller (DrawX/DrawY/blank) and the DAC outputs.
- Renders a scrollable tile-map background through a writable palette, with up to NUM_SPRITES solid-colour boxes overlaid on top.
- The tile map and palette are runtime-writable by game logic.
- On reset, an init state machine reloads the default map and palette.

Parameters:
- TILE_SHIFT, 5, log2 of tile edge in pixels (32 px tiles)
- MAP_W, 20, tile columns in the map
- MAP_H, 15, tile rows in the map
- IDX_W, 2, palette index width; palette depth is 2**IDX_W
- NUM_SPRITES, 2, number of overlay boxes; index 0 has highest priority

Ports:
- Clk  in  1  pixel clock
- Reset  in  1  synchronous, active-high reset
- blank  in  1  1 = active video; 0 forces black
- DrawX, DrawY  in  10 each  current pixel coordinate
- scroll_x  in  11  horizontal scroll offset in pixels; legal range 0..MAP_W*2**TILE_SHIFT-1
- map_we  in  1  tile map write strobe
- map_col  in  5  tile map write column
- map_row  in  4  tile map write row
- map_wdata  in  IDX_W  tile map write data
- pal_we  in  1  palette write strobe
- pal_idx  in  IDX_W  palette entry to write
- pal_rgb  in  24  palette write data {R,G,B}
- spr_en  in  NUM_SPRITES  per-sprite enable
- spr_x, spr_y  in  NUM_SPRITES*10 each  sprite centre coordinates (flattened; sprite k in bits [10k+9:10k])
- spr_hw, spr_hh  in  NUM_SPRITES*10 each  sprite half-width and half-height
- spr_rgb  in  NUM_SPRITES*24  sprite colour
- init_done  out  1  1 once the map and palette init has completed
- Red, Green, Blue  out  8 each  registered pixel colour

Behaviour:
- Reset:
  - Red/Green/Blue = 0 and init_done = 0 on the cycle after Reset is sampled high.
  - FSM enters INIT with cell counter = 0.
  - Reset asserted during INIT or RUN restarts INIT from cell 0.
- FSM has two states.
  - INIT: writes one map cell per cycle, row-major, value = (row + col) mod 2**IDX_W. After MAP_W*MAP_H cycles it moves to RUN and sets init_done = 1.
  - In INIT, the palette is loaded in the same first cycle with: idx0 = 00_00_7F, idx1 = 8D_FC_C7, idx2 = 11_5C_C7, idx3 = 22_FC_AA, all other entries = 0.
  - In INIT, map_we and pal_we are ignored and RGB outputs are 0.
  - RUN is held until Reset.
- Pipeline latency is 2 cycles: the outputs at cycle t+2 correspond to DrawX/DrawY/blank/sprite inputs sampled at cycle t.
  - S1: compute the map address, issue a synchronous map read, register blank and the sprite-hit vector.
  - S2: palette lookup and sprite mux into the output registers.
- Scroll and address:
  - wx = DrawX + scroll_x, computed at 11 bits. If wx >= MAP_W<<TILE_SHIFT, subtract MAP_W<<TILE_SHIFT (wrap).
  - col = wx >> TILE_SHIFT; row = DrawY >> TILE_SHIFT.
  - If row >= MAP_H, the tile index is forced to 0.
- Sprite hit for sprite k:
  - Condition: spr_en[k], DrawX + hw >= x, DrawX <= x + hw, DrawY + hh >= y, DrawY <= y + hh.
  - All sums are 11 bits so there is no underflow or wrap; the box is inclusive.
- Colour priority at S2:
  1. registered blank = 0 gives black;
  2. otherwise the lowest-index hit sprite gives spr_rgb;
  3. otherwise the palette entry of the tile index.
- Map write port (RUN only):
  - Writes are ignored if map_col >= MAP_W or map_row >= MAP_H.
  - A read and write of the same cell in one cycle returns the old data; the new data is visible from the next read.
- Palette write (RUN only) takes effect for pixels whose S2 stage occurs on the following cycle or later.

Decomposition:
- Package tile_color_pkg:
  - rgb_t typedef (24-bit struct with R/G/B);
  - default palette constant array;
  - WORLD_W function (MAP_W << TILE_SHIFT);
  - FSM state enum {INIT, RUN}.
- Sub-module tile_map_ram: a single-port-write, single-port-read synchronous RAM of MAP_W*MAP_H x IDX_W with read-old-on-collision. It takes its write port from an init/user mux in the parent.

Test Plan:
- Reset pulse, then wait: init_done rises exactly 300 cycles after Reset is released. A read at DrawX=33, DrawY=0 (cell 0,1 = idx1) gives RGB 8D,FC,C7 two cycles later.
- blank=0 with sprite 0 covering the pixel gives RGB 00,00,00. blank=1 at DrawX=0, DrawY=0, scroll 0 gives idx0 = 00,00,7F.
- Sprite 0 at (100,100), hw=8, hh=16: DrawX=92/108 and DrawY=84/116 hit; 91, 109, 83, 117 miss. Sprite 1 overlapping the same pixel yields sprite 0's colour. x=4, hw=8 gives DrawX=0 hit (no underflow).
- scroll_x=630, DrawX=20 wraps to wx=10, giving col 0. DrawY=480 (row 15) gives the idx0 colour.
- Write map(3,2)=3 and read the same cell in the same cycle: old colour idx1 (row 2 + col 3 = 5 mod 4). The next line shows 22,FC,AA. Write col=20 is ignored.
- Reset asserted mid-INIT at cell 150: outputs go to 0, and init_done rises 300 cycles after Reset is released. pal_we during INIT is ignored, so the default palette is retained.
